// File: rtl/apb_master_if.sv
// Command/response port and APB requester signals for apb_master.
`timescale 1ns/1ps
interface apb_master_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   // Host command port
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   // Host response port
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   // APB bus
   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;

   // Requester view
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );

   // Host + completer view
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and reports completion (or a wait-state timeout) on a one-cycle response.
`timescale 1ns/1ps
module apb_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          PCLK,
   input  logic          PRESET,
   apb_master_if.master  bus
);

   // TIMEOUT=0 disables the abort; keep a 1-bit counter so widths stay legal.
   localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic             TO_EN    = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic              psel_q,   psel_d;
   logic              pen_q,    pen_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q,  paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rvld_q,   rvld_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic              rerr_q,   rerr_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              expire;

   // Abort fires on the wait edge that would bring the counter to TIMEOUT.
   assign expire = TO_EN && (cnt_q == CNT_LAST);

   // State and registered outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= S_IDLE;
         psel_q   <= 1'b0;
         pen_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rvld_q   <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         psel_q   <= psel_d;
         pen_q    <= pen_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rvld_q   <= rvld_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state and next output values; address/data/direction hold in IDLE
   always_comb begin
      state_d  = state_q;
      psel_d   = 1'b0;
      pen_d    = 1'b0;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rvld_d   = 1'b0;
      rdata_d  = '0;
      rerr_d   = 1'b0;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d  = S_SETUP;
               psel_d   = 1'b1;
               pwrite_d = bus.cmd_write;
               paddr_d  = bus.cmd_addr;
               pwdata_d = bus.cmd_wdata;
               cnt_d    = '0;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            psel_d  = 1'b1;
            pen_d   = 1'b1;
         end
         S_ACCESS: begin
            if (bus.PREADY) begin
               state_d = S_IDLE;
               rvld_d  = 1'b1;
               rdata_d = pwrite_q ? '0 : bus.PRDATA;
            end else if (expire) begin
               state_d = S_IDLE;
               rvld_d  = 1'b1;
               rerr_d  = 1'b1;
            end else begin
               psel_d = 1'b1;
               pen_d  = 1'b1;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cmd_ready = (state_q == S_IDLE) & ~PRESET;
   assign bus.PSELx     = psel_q;
   assign bus.PENABLE   = pen_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rvld_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = rerr_q;

endmodule
